// File: rtl/game_pkg.sv
// Shared definitions for the 3x3 keypad game: FSM states, winner codes,
// win-line masks, player constants and keypad codes.
package game_pkg;

  localparam int unsigned N_CELLS = 9;
  localparam int unsigned N_LINES = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_CHECK = 3'd2,
    ST_WRITE = 3'd3,
    ST_JUDGE = 3'd4,
    ST_OVER  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_X    = 2'b01,
    WIN_O    = 2'b10,
    WIN_DRAW = 2'b11
  } winner_t;

  localparam logic PLAYER_X = 1'b0;
  localparam logic PLAYER_O = 1'b1;

  localparam logic [3:0] KEY_RESTART = 4'hF;

  // Cell i is bit i, cells numbered row-major from the top-left corner.
  localparam logic [N_LINES-1:0][N_CELLS-1:0] WIN_LINE = {
    9'h007, 9'h038, 9'h1C0,   // rows
    9'h049, 9'h092, 9'h124,   // columns
    9'h111, 9'h054            // diagonals
  };

  // Keys 1..9 select a cell; everything else is not a move.
  function automatic logic is_cell_key(input logic [3:0] key);
    return (key >= 4'd1) && (key <= 4'd9);
  endfunction

endpackage

// File: rtl/game_win_check.sv
// win_check: combinational three-in-a-row detector.
// Ports: i_board [8:0] cells owned by one player; o_win 1 when any of the
// eight win lines is fully covered by i_board.
module win_check
  import game_pkg::*;
(
  input  logic [N_CELLS-1:0] i_board,
  output logic               o_win
);

  always_comb begin
    o_win = 1'b0;
    for (int unsigned i = 0; i < N_LINES; i++) begin
      if ((i_board & WIN_LINE[i]) == WIN_LINE[i]) o_win = 1'b1;
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// game_ctrl: move sequencer for the two-player 3x3 keypad game. Owns the
// board and the turn flag, rejects occupied cells, judges win/draw after each
// move and alternates turns.
// Ports:
//   clk, rst (async active-low)
//   keypad_in[3:0], keypad_valid   key code and its one-cycle strobe
//   en          accepting a move
//   whose       player to move (0 = X, 1 = O)
//   board_x/o   cells held by X / O
//   move_done, illegal, timeout    one-cycle pulses
//   game_over, winner[1:0]         game result
// Optional feature: define TURN_TIMEOUT_EN to forfeit a turn after
// TIMEOUT_CYC idle cycles in WAIT; otherwise timeout is tied low.
module game_ctrl
  import game_pkg::*;
`ifdef TURN_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYC = 1000
)
`endif
(
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         keypad_in,
  input  logic               keypad_valid,
  output logic               en,
  output logic               whose,
  output logic [N_CELLS-1:0] board_x,
  output logic [N_CELLS-1:0] board_o,
  output logic               move_done,
  output logic               illegal,
  output logic               timeout,
  output logic               game_over,
  output logic [1:0]         winner
);

  state_t             r_state;
  logic [3:0]         r_cell;
  logic [N_CELLS-1:0] w_occupied;
  logic [N_CELLS-1:0] w_mover_board;
  logic               w_win;
  logic               w_cell_key;
  logic               w_restart;

  assign w_occupied    = board_x | board_o;
  assign w_mover_board = (whose == PLAYER_O) ? board_o : board_x;
  assign w_cell_key    = keypad_valid && is_cell_key(keypad_in);
  assign w_restart     = keypad_valid && (keypad_in == KEY_RESTART);

  win_check u_win_check (
    .i_board (w_mover_board),
    .o_win   (w_win)
  );

`ifdef TURN_TIMEOUT_EN
  localparam int unsigned TMR_W = ($clog2(TIMEOUT_CYC) > 10) ? $clog2(TIMEOUT_CYC) : 10;
  logic [TMR_W-1:0] r_timer;
  logic             w_expire;
  assign w_expire = (r_timer == TMR_W'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

  // Game sequencer; every output is a register updated here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_cell    <= 4'd0;
      en        <= 1'b0;
      whose     <= PLAYER_X;
      board_x   <= '0;
      board_o   <= '0;
      move_done <= 1'b0;
      illegal   <= 1'b0;
      game_over <= 1'b0;
      winner    <= WIN_NONE;
`ifdef TURN_TIMEOUT_EN
      timeout   <= 1'b0;
      r_timer   <= '0;
`endif
    end else begin
      move_done <= 1'b0;
      illegal   <= 1'b0;
`ifdef TURN_TIMEOUT_EN
      timeout   <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          board_x <= '0;
          board_o <= '0;
          whose   <= PLAYER_X;
          winner  <= WIN_NONE;
          en      <= 1'b1;
          r_state <= ST_WAIT;
`ifdef TURN_TIMEOUT_EN
          r_timer <= '0;
`endif
        end
        ST_WAIT: begin
          // A real key beats a timer expiry in the same cycle.
          if (w_cell_key) begin
            r_cell  <= keypad_in - 4'd1;
            en      <= 1'b0;
            r_state <= ST_CHECK;
          end else if (w_restart) begin
            en      <= 1'b0;
            r_state <= ST_IDLE;
          end
`ifdef TURN_TIMEOUT_EN
          else if (w_expire) begin
            whose   <= ~whose;
            timeout <= 1'b1;
            r_timer <= '0;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
`endif
        end
        ST_CHECK: begin
          if (w_occupied[r_cell]) begin
            illegal <= 1'b1;
            en      <= 1'b1;
            r_state <= ST_WAIT;
`ifdef TURN_TIMEOUT_EN
            r_timer <= '0;
`endif
          end else begin
            r_state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (whose == PLAYER_O) board_o[r_cell] <= 1'b1;
          else                   board_x[r_cell] <= 1'b1;
          move_done <= 1'b1;
          r_state   <= ST_JUDGE;
        end
        ST_JUDGE: begin
          if (w_win) begin
            winner    <= (whose == PLAYER_O) ? WIN_O : WIN_X;
            game_over <= 1'b1;
            r_state   <= ST_OVER;
          end else if (&w_occupied) begin
            winner    <= WIN_DRAW;
            game_over <= 1'b1;
            r_state   <= ST_OVER;
          end else begin
            whose   <= ~whose;
            en      <= 1'b1;
            r_state <= ST_WAIT;
`ifdef TURN_TIMEOUT_EN
            r_timer <= '0;
`endif
          end
        end
        ST_OVER: begin
          if (w_restart) begin
            game_over <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: a game-level model (cell array plus move timing)
// checked against the DUT every falling edge, plus literal checkpoints.
module tb_game_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] keypad_in = 4'd0;
  logic       keypad_valid = 1'b0;
  logic       en, whose, move_done, illegal, timeout, game_over;
  logic [8:0] board_x, board_o;
  logic [1:0] winner;

  localparam int TO_CYC = 8;

  always #5 clk = ~clk;

`ifdef TURN_TIMEOUT_EN
  game_ctrl #(.TIMEOUT_CYC(TO_CYC)) dut (
`else
  game_ctrl dut (
`endif
    .clk(clk), .rst(rst), .keypad_in(keypad_in), .keypad_valid(keypad_valid),
    .en(en), .whose(whose), .board_x(board_x), .board_o(board_o),
    .move_done(move_done), .illegal(illegal), .timeout(timeout),
    .game_over(game_over), .winner(winner)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- game model ----------------
  int         cells [9];   // 0 empty, 1 X, 2 O
  bit         m_en, m_whose, m_over, m_md, m_ill, m_to, m_idle_pend;
  logic [1:0] m_winner;
  int         cyc, acc_cyc, acc_cell, wait_cnt;

  function automatic bit line_won(input int p);
    for (int r = 0; r < 3; r++)
      if (cells[3*r] == p && cells[3*r+1] == p && cells[3*r+2] == p) return 1'b1;
    for (int c = 0; c < 3; c++)
      if (cells[c] == p && cells[c+3] == p && cells[c+6] == p) return 1'b1;
    if (cells[0] == p && cells[4] == p && cells[8] == p) return 1'b1;
    if (cells[2] == p && cells[4] == p && cells[6] == p) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [8:0] board_of(input int p);
    logic [8:0] b = '0;
    for (int i = 0; i < 9; i++) if (cells[i] == p) b[i] = 1'b1;
    return b;
  endfunction

  function automatic bit all_full();
    for (int i = 0; i < 9; i++) if (cells[i] == 0) return 1'b0;
    return 1'b1;
  endfunction

  task model_reset();
    for (int i = 0; i < 9; i++) cells[i] = 0;
    m_en = 0; m_whose = 0; m_over = 0; m_md = 0; m_ill = 0; m_to = 0;
    m_winner = 2'b00; m_idle_pend = 1; acc_cyc = -100; cyc = 0; wait_cnt = 0;
  endtask

  task model_step();
    int p;
    m_md = 0; m_ill = 0; m_to = 0;
    if (m_idle_pend) begin
      for (int i = 0; i < 9; i++) cells[i] = 0;
      m_whose = 0; m_winner = 2'b00; m_en = 1; m_idle_pend = 0; wait_cnt = 0;
    end else if (acc_cyc >= 0 && cyc == acc_cyc + 1) begin
      if (cells[acc_cell] != 0) begin
        m_ill = 1; m_en = 1; acc_cyc = -100; wait_cnt = 0;
      end
    end else if (acc_cyc >= 0 && cyc == acc_cyc + 2) begin
      cells[acc_cell] = m_whose ? 2 : 1;
      m_md = 1;
    end else if (acc_cyc >= 0 && cyc == acc_cyc + 3) begin
      acc_cyc = -100;
      p = m_whose ? 2 : 1;
      if (line_won(p)) begin
        m_winner = 2'(p); m_over = 1;
      end else if (all_full()) begin
        m_winner = 2'b11; m_over = 1;
      end else begin
        m_whose = ~m_whose; m_en = 1; wait_cnt = 0;
      end
    end else if (m_en) begin
      if (keypad_valid && keypad_in >= 4'd1 && keypad_in <= 4'd9) begin
        acc_cyc = cyc; acc_cell = int'(keypad_in) - 1; m_en = 0;
      end else if (keypad_valid && keypad_in == 4'hF) begin
        m_idle_pend = 1; m_en = 0;
      end
`ifdef TURN_TIMEOUT_EN
      else if (wait_cnt == TO_CYC - 1) begin
        m_whose = ~m_whose; m_to = 1; wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
`endif
    end else if (m_over) begin
      if (keypad_valid && keypad_in == 4'hF) begin
        m_over = 0; m_idle_pend = 1;
      end
    end
    cyc++;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else      model_step();
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst) begin
      chk("en",        en,        m_en);
      chk("whose",     whose,     m_whose);
      chk("board_x",   board_x,   board_of(1));
      chk("board_o",   board_o,   board_of(2));
      chk("move_done", move_done, m_md);
      chk("illegal",   illegal,   m_ill);
      chk("timeout",   timeout,   m_to);
      chk("game_over", game_over, m_over);
      chk("winner",    winner,    m_winner);
    end
  end

  // ---------------- stimulus ----------------
  task automatic press(input logic [3:0] key);
    keypad_in = key; keypad_valid = 1'b1;
    @(negedge clk);
    keypad_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic move(input logic [3:0] key);
    press(key);
    idle(3);
  endtask

  initial begin
    #2 rst = 1'b0;
    #1;
    chk("rst_en", en, 1'b0);
    chk("rst_winner", winner, 2'b00);
    chk("rst_boards", {board_x, board_o}, 18'h0);
    idle(2);
    rst = 1'b1;

    // 1: en rises after one IDLE cycle
    chk("t1_en_idle", en, 1'b0);
    idle(1);
    chk("t1_en", en, 1'b1);
    chk("t1_whose", whose, 1'b0);
    chk("t1_boards", {board_x, board_o}, 18'h0);

    // 2: X wins along the top row
    move(4'd1); move(4'd4); move(4'd2); move(4'd5); move(4'd3);
    chk("t2_board_x", board_x, 9'h007);
    chk("t2_board_o", board_o, 9'h018);
    chk("t2_winner", winner, 2'b01);
    chk("t2_over", game_over, 1'b1);
    chk("t2_en", en, 1'b0);

    // 5: non-restart key ignored in OVER, then restart
    press(4'd7); idle(2);
    chk("t5_hold_x", board_x, 9'h007);
    chk("t5_hold_over", game_over, 1'b1);
    press(4'hF);
    chk("t5_idle_en", en, 1'b0);
    chk("t5_idle_over", game_over, 1'b0);
    idle(1);
    chk("t5_boards", {board_x, board_o}, 18'h0);
    chk("t5_whose", whose, 1'b0);
    chk("t5_en", en, 1'b1);
    chk("t5_winner", winner, 2'b00);

    // 3: O picks X's cell
    move(4'd5);
    press(4'd5); idle(1);
    chk("t3_illegal", illegal, 1'b1);
    chk("t3_board_o", board_o, 9'h000);
    chk("t3_whose", whose, 1'b1);
    chk("t3_en", en, 1'b1);
    idle(1);
    chk("t3_pulse_end", illegal, 1'b0);

    // ignored codes in WAIT
    press(4'd0); press(4'd10); idle(1);
    chk("ign_en", en, 1'b1);
    chk("ign_board", board_x, 9'h010);

    // 4: draw; the second key lands in CHECK and is dropped
    press(4'hF); idle(1);
    press(4'd1); press(4'd2); idle(2);
    chk("t4_drop", {board_x, board_o}, {9'h001, 9'h000});
    move(4'd2); move(4'd3); move(4'd5); move(4'd4);
    move(4'd6); move(4'd8); move(4'd7); move(4'd9);
    chk("t4_winner", winner, 2'b11);
    chk("t4_full", board_x | board_o, 9'h1FF);
    chk("t4_board_x", board_x, 9'h18D);
    chk("t4_board_o", board_o, 9'h072);

    // 6: turn timeout (or its absence)
    press(4'hF); idle(1);
`ifdef TURN_TIMEOUT_EN
    idle(TO_CYC - 1);
    chk("t6_no_to_yet", timeout, 1'b0);
    idle(1);
    chk("t6_timeout", timeout, 1'b1);
    chk("t6_whose", whose, 1'b1);
`else
    idle(12);
    chk("t6_timeout_tied", timeout, 1'b0);
    chk("t6_whose", whose, 1'b0);
`endif

    // reset while JUDGE holds a fresh move
    press(4'd1); idle(2);
    chk("rj_move_done", move_done, 1'b1);
    #1 rst = 1'b0;
    #1;
    chk("rj_en", en, 1'b0);
    chk("rj_whose", whose, 1'b0);
    chk("rj_boards", {board_x, board_o}, 18'h0);
    chk("rj_pulses", {move_done, illegal, timeout}, 3'b000);
    chk("rj_over", {game_over, winner}, 3'b000);
    idle(2);
    rst = 1'b1;
    idle(3);
    chk("rj_en_back", en, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
